// File: rtl/hazard_ctrl_if.sv
// Pipeline hazard control bundle: ID/EX/MEM observations in, stall/flush/freeze controls out.
// The perf counter outputs are always present; they read 0 unless HAZARD_PERF_EN is defined.
interface hazard_ctrl_if;
  logic [4:0]  IFID_RS1addr_i;
  logic [4:0]  IFID_RS2addr_i;
  logic        RS1use_i;
  logic        RS2use_i;
  logic        IDEX_MemRead_i;
  logic [4:0]  IDEX_RDaddr_i;
  logic        Branch_i;
  logic        EXMEM_MemAccess_i;
  logic        PCWrite_o;
  logic        IFIDWrite_o;
  logic        IFIDFlush_o;
  logic        NoOp_o;
  logic        Freeze_o;
  logic        busy_o;
  logic [31:0] stall_cnt_o;
  logic [31:0] flush_cnt_o;
  logic [31:0] freeze_cnt_o;

  modport master (
    output IFID_RS1addr_i, IFID_RS2addr_i, RS1use_i, RS2use_i,
           IDEX_MemRead_i, IDEX_RDaddr_i, Branch_i, EXMEM_MemAccess_i,
    input  PCWrite_o, IFIDWrite_o, IFIDFlush_o, NoOp_o, Freeze_o, busy_o,
           stall_cnt_o, flush_cnt_o, freeze_cnt_o
  );

  modport slave (
    input  IFID_RS1addr_i, IFID_RS2addr_i, RS1use_i, RS2use_i,
           IDEX_MemRead_i, IDEX_RDaddr_i, Branch_i, EXMEM_MemAccess_i,
    output PCWrite_o, IFIDWrite_o, IFIDFlush_o, NoOp_o, Freeze_o, busy_o,
           stall_cnt_o, flush_cnt_o, freeze_cnt_o
  );
endinterface

// File: rtl/hazard_ctrl.sv
// ID/EX hazard controller: load-use stall, branch flush, multi-cycle data-memory freeze.
// Optional perf counters are built only when HAZARD_PERF_EN is defined.
//
// state    | meaning
// RUN      | normal issue; a memory access in MEM may start a freeze
// MEM_WAIT | freeze in progress, cnt counts remaining cycles down to 0
// MEM_DONE | last cycle of the access; no freeze, retrigger masked
module hazard_ctrl #(
  parameter int MEM_LAT = 1
) (
  input  logic         clk_i,
  input  logic         rst_i,
  hazard_ctrl_if.slave bus
);

  typedef enum logic [1:0] {RUN, MEM_WAIT, MEM_DONE} state_t;

  localparam bit       LAT_MULTI = (MEM_LAT >= 2);
  localparam bit       LAT_TWO   = (MEM_LAT == 2);
  localparam logic [3:0] WAIT_INIT = (MEM_LAT > 2) ? 4'(MEM_LAT - 3) : 4'd0;

  state_t     state;
  logic [3:0] cnt;
  logic       luh;
  logic       mtrig;
  logic       freeze;

  assign luh = bus.IDEX_MemRead_i && (bus.IDEX_RDaddr_i != 5'd0) &&
               ((bus.RS1use_i && (bus.IFID_RS1addr_i == bus.IDEX_RDaddr_i)) ||
                (bus.RS2use_i && (bus.IFID_RS2addr_i == bus.IDEX_RDaddr_i)));
  assign mtrig  = (state == RUN) && bus.EXMEM_MemAccess_i && LAT_MULTI;
  assign freeze = mtrig || (state == MEM_WAIT);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state <= RUN;
      cnt   <= 4'd0;
    end else begin
      case (state)
        RUN: begin
          if (mtrig) begin
            if (LAT_TWO) begin
              state <= MEM_DONE;
            end else begin
              state <= MEM_WAIT;
              cnt   <= WAIT_INIT;
            end
          end
        end
        MEM_WAIT: begin
          if (cnt == 4'd0) state <= MEM_DONE;
          else             cnt   <= cnt - 4'd1;
        end
        default: state <= RUN;
      endcase
    end
  end

  // Freeze outranks load-use, which outranks branch: a branch alongside a
  // load-use sees stale operands and simply re-resolves next cycle.
  always_comb begin
    bus.PCWrite_o   = 1'b1;
    bus.IFIDWrite_o = 1'b1;
    bus.IFIDFlush_o = 1'b0;
    bus.NoOp_o      = 1'b0;
    bus.Freeze_o    = 1'b0;
    bus.busy_o      = (state != RUN);
    if (rst_i) begin
      bus.PCWrite_o   = 1'b0;
      bus.IFIDWrite_o = 1'b0;
      bus.NoOp_o      = 1'b1;
      bus.busy_o      = 1'b0;
    end else if (freeze) begin
      bus.Freeze_o    = 1'b1;
      bus.PCWrite_o   = 1'b0;
      bus.IFIDWrite_o = 1'b0;
    end else if (luh) begin
      bus.PCWrite_o   = 1'b0;
      bus.IFIDWrite_o = 1'b0;
      bus.NoOp_o      = 1'b1;
    end else if (bus.Branch_i) begin
      bus.IFIDFlush_o = 1'b1;
    end
  end

`ifdef HAZARD_PERF_EN
  logic [31:0] stall_cnt;
  logic [31:0] flush_cnt;
  logic [31:0] freeze_cnt;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      stall_cnt  <= 32'd0;
      flush_cnt  <= 32'd0;
      freeze_cnt <= 32'd0;
    end else begin
      if (!freeze && luh && (stall_cnt != 32'hFFFF_FFFF))
        stall_cnt <= stall_cnt + 32'd1;
      if (bus.IFIDFlush_o && (flush_cnt != 32'hFFFF_FFFF))
        flush_cnt <= flush_cnt + 32'd1;
      if (freeze && (freeze_cnt != 32'hFFFF_FFFF))
        freeze_cnt <= freeze_cnt + 32'd1;
    end
  end

  assign bus.stall_cnt_o  = stall_cnt;
  assign bus.flush_cnt_o  = flush_cnt;
  assign bus.freeze_cnt_o = freeze_cnt;
`else
  assign bus.stall_cnt_o  = 32'd0;
  assign bus.flush_cnt_o  = 32'd0;
  assign bus.freeze_cnt_o = 32'd0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: driver pushes model expectations, negedge monitor compares.
// The model tracks remaining freeze cycles and a post-access mask rather than FSM states.
module tb_hazard_ctrl;
  localparam int LAT = 4;

  typedef struct {
    bit          pcw, ifw, fl, noop, frz, busy;
    logic [31:0] sc, fc, zc;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  hazard_ctrl_if bus ();

  hazard_ctrl #(.MEM_LAT(LAT)) dut (.clk_i(clk), .rst_i(rst), .bus(bus));

  always #5 clk = ~clk;

  exp_t q[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  int          frz_left = 0;
  bit          mask     = 1'b0;
  logic [31:0] m_sc = 0, m_fc = 0, m_zc = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, req, $time);
    end
  endtask

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  task automatic cyc(input bit r, input logic [4:0] a1, input logic [4:0] a2,
                     input bit u1, input bit u2, input bit mr, input logic [4:0] rd,
                     input bit br, input bit ma);
    exp_t e;
    bit   hz, bsy, frz;
    @(posedge clk);
    #1;
    rst = r;
    bus.IFID_RS1addr_i = a1;  bus.IFID_RS2addr_i = a2;
    bus.RS1use_i = u1;        bus.RS2use_i = u2;
    bus.IDEX_MemRead_i = mr;  bus.IDEX_RDaddr_i = rd;
    bus.Branch_i = br;        bus.EXMEM_MemAccess_i = ma;
    e = '{pcw: 1'b0, ifw: 1'b0, fl: 1'b0, noop: 1'b1, frz: 1'b0, busy: 1'b0,
          sc: 32'd0, fc: 32'd0, zc: 32'd0};
    if (r) begin
      frz_left = 0; mask = 1'b0;
      m_sc = 0; m_fc = 0; m_zc = 0;
    end else begin
      hz  = mr && (rd != 0) && ((u1 && a1 == rd) || (u2 && a2 == rd));
      bsy = (frz_left > 0) || mask;
      if (frz_left == 0 && !mask && ma && LAT >= 2) frz_left = LAT - 1;
      frz = (frz_left > 0);
      e.frz = frz; e.busy = bsy;
      if (frz)     begin e.pcw = 0; e.ifw = 0; e.fl = 0; e.noop = 0; end
      else if (hz) begin e.pcw = 0; e.ifw = 0; e.fl = 0; e.noop = 1; end
      else if (br) begin e.pcw = 1; e.ifw = 1; e.fl = 1; e.noop = 0; end
      else         begin e.pcw = 1; e.ifw = 1; e.fl = 0; e.noop = 0; end
`ifdef HAZARD_PERF_EN
      e.sc = m_sc; e.fc = m_fc; e.zc = m_zc;
`endif
      if (!frz && hz) m_sc = sat_inc(m_sc);
      if (e.fl)       m_fc = sat_inc(m_fc);
      if (frz)        m_zc = sat_inc(m_zc);
      if (frz) begin
        frz_left--;
        mask = (frz_left == 0);
      end else begin
        mask = 1'b0;
      end
    end
    q.push_back(e);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      chk("PCWrite",   32'(bus.PCWrite_o),   32'(e.pcw));
      chk("IFIDWrite", 32'(bus.IFIDWrite_o), 32'(e.ifw));
      chk("IFIDFlush", 32'(bus.IFIDFlush_o), 32'(e.fl));
      chk("NoOp",      32'(bus.NoOp_o),      32'(e.noop));
      chk("Freeze",    32'(bus.Freeze_o),    32'(e.frz));
      chk("busy",      32'(bus.busy_o),      32'(e.busy));
      chk("stall_cnt",  bus.stall_cnt_o,  e.sc);
      chk("flush_cnt",  bus.flush_cnt_o,  e.fc);
      chk("freeze_cnt", bus.freeze_cnt_o, e.zc);
    end
  end

  initial begin
    bus.IFID_RS1addr_i = 0; bus.IFID_RS2addr_i = 0;
    bus.RS1use_i = 0; bus.RS2use_i = 0;
    bus.IDEX_MemRead_i = 0; bus.IDEX_RDaddr_i = 0;
    bus.Branch_i = 0; bus.EXMEM_MemAccess_i = 0;

    cyc(1, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 0);
    idle(1);
    // load-use on rs1, then release
    cyc(0, 5, 0, 1, 0, 1, 5, 0, 0);
    idle(1);
    // rd = x0 and an unused rs2 never stall
    cyc(0, 0, 0, 1, 0, 1, 0, 0, 0);
    cyc(0, 0, 7, 0, 0, 1, 7, 0, 0);
    cyc(0, 0, 7, 0, 1, 1, 7, 0, 0);
    // branch alone, then branch with load-use
    cyc(0, 0, 0, 0, 0, 0, 0, 1, 0);
    cyc(0, 3, 0, 1, 0, 1, 3, 1, 0);
    idle(1);
    // held access with a load-use present throughout
    for (int i = 0; i < 6; i++) cyc(0, 9, 0, 1, 0, 1, 9, 0, 1);
    idle(2);
    // reset asynchronously on freeze cycle 2, then a fresh access
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 1);
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 1);
    idle(5);
    // perf mix: 2 stalls, 1 flush, 1 access
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc(0, 4, 0, 1, 0, 1, 4, 0, 0);
    cyc(0, 0, 6, 0, 1, 1, 6, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0, 1, 0);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 1);
    idle(5);
    // random traffic with small register indices to provoke hazards
    for (int i = 0; i < 600; i++) begin
      cyc(($urandom_range(63) == 0),
          5'($urandom_range(3)), 5'($urandom_range(3)),
          1'($urandom), 1'($urandom), 1'($urandom),
          5'($urandom_range(3)), 1'($urandom),
          ($urandom_range(3) == 0));
    end
    idle(2);
    repeat (3) @(posedge clk);
    chk("scoreboard_drained", 32'(q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
